regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Write-back scheduler for the 32x32 integer register file: arbitrates NSRC write-back requesters
//  (src0 ALU, src1 LSU, src2 predictor path) onto the regfile's two write ports (A: rd/data_des,
//  B: rdpred/data_despred). Keeps a per-register busy scoreboard for decode hazard checks.
//  Sits between the execute/memory units and the register file.
// PARAMETERS
//  NSRC   3   number of write-back requesters
//  XLEN   32  register data width
//  RAW    5   register address width (32 registers, x0 hardwired zero)
// PORTS
//  clk        in   1         clock; all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   NSRC      write-back request per source
//  req_rd     in   NSRC*RAW  destination register per source (source i at [i*RAW +: RAW])
//  req_data   in   NSRC*XLEN write data per source
//  req_ready  out  NSRC      grant/accept this cycle (combinational)
//  wa_valid   out  1         port A write enable  -> data_valid
//  wa_rd      out  RAW       port A address       -> rd
//  wa_data    out  XLEN      port A data          -> data_des
//  wb_valid   out  1         port B write enable  -> data_validpred
//  wb_rd      out  RAW       port B address       -> rdpred
//  wb_data    out  XLEN      port B data          -> data_despred
//  iss_valid  in   1         instruction issued with destination iss_rd
//  iss_rd     in   RAW       destination of issued instruction
//  lk_rs1     in   RAW       scoreboard lookup address 1
//  lk_rs2     in   RAW       scoreboard lookup address 2
//  busy_rs1   out  1         lk_rs1 has a pending write (combinational)
//  busy_rs2   out  1         lk_rs2 has a pending write (combinational)
// BEHAVIOUR
//  - Reset (async, rst_n=0): wa_*/wb_* = 0, all busy bits 0, rr pointer 0; in-flight grants dropped.
//  - Arbitration: scan sources from rr, wrapping modulo NSRC; first valid -> port A, second -> port B.
//    At most 2 grants/cycle; remaining valid sources see req_ready=0 and must hold request stable.
//  - Same-rd conflict: second candidate with rd equal to port A's rd is skipped (ready=0) this cycle;
//    scan continues for another port-B candidate.
//  - rd==0 requests: req_ready=1 when reached in scan, consume no port, never written.
//  - Latency: granted request appears on wa_*/wb_* registered, one cycle after req_valid&req_ready;
//    regfile writes on the following edge. Unused port: *_valid=0, rd/data hold 0.
//  - rr update: one past the last granted source (rd==0 accepts count); unchanged when no grant.
//  - Scoreboard: busy[iss_rd] set at edge when iss_valid && iss_rd!=0; busy[r] cleared at edge where
//    wa_valid&&wa_rd==r or wb_valid&&wb_rd==r. Set and clear same r same edge: set wins.
//  - busy_rs* = busy[lk_rs*]; always 0 for x0. Writes from sources not marked busy are legal.
// CONFIGURATION
//  WB_FWD_EN defined: extra outputs fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data (XLEN) from
//    registered wa_*/wb_* matching lk_rs*; port B data wins if both match; busy_rs* masked to 0 on hit.
//  WB_FWD_EN undefined: ports absent; busy_rs* stays high until the regfile write edge.
// STRUCTURE
//  Package regfile_sched_pkg: XLEN, RAW, NSRC constants, src_idx_t, wb_port_t {valid, rd, data}.
//  Sub-module reg_scoreboard: 32 busy bits, set/clear/lookup; top holds arbiter, rr and output regs.
// TESTING
//  1 Reset: rst_n low mid-grant with src0 rd=5 -> wa_valid=0, busy_rs1(lk=5)=0 immediately.
//  2 src0 rd=3 0x11, src1 rd=4 0x22, rr=0 -> next cycle wa=(3,0x11), wb=(4,0x22); rr=2.
//  3 src0 and src2 both rd=7, rr=0 -> src0 on A, src2 ready=0; src2 on A next cycle; final x7=src2.
//  4 All 3 valid, rd 1/2/3, held 3 cycles -> grant order {0,1},{2,0},{1,2}; no source starved.
//  5 iss rd=9; src1 writes rd=9 two cycles later -> busy_rs1(lk=9)=1 until write edge, then 0.
//  6 src1 rd=0 0xFFFF -> ready=1, wa_valid=wb_valid=0; WB_FWD_EN: wa rd=6 0xAB -> fwd_rs2_hit=1, 0xAB.

Source files
------------

// File: rtl/regfile_sched_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Contents: NSRC/XLEN/RAW/NREG widths, src_idx_t source index, wb_port_t
// write-port payload, src_wrap() modulo-NSRC index helper.
package regfile_sched_pkg;

    localparam int unsigned NSRC = 3;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RAW  = 5;
    localparam int unsigned NREG = 1 << RAW;
    localparam int unsigned SIW  = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef logic [SIW-1:0] src_idx_t;

    typedef struct packed {
        logic            valid;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } wb_port_t;

    // Wrap a source index in [0, 2*NSRC) back into [0, NSRC).
    function automatic src_idx_t src_wrap(input int unsigned v);
        int unsigned w;
        w = (v >= NSRC) ? v - NSRC : v;
        return src_idx_t'(w);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard used for decode hazard checks.
// Ports: clk, rst_n; set_valid/set_rd (issue marks a register busy);
// clr_a_*/clr_b_* (regfile write edge clears); lk_rs1/lk_rs2 lookups
// with combinational busy_rs1/busy_rs2. x0 is never busy.
module reg_scoreboard
    import regfile_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           set_valid,
    input  logic [RAW-1:0] set_rd,
    input  logic           clr_a_valid,
    input  logic [RAW-1:0] clr_a_rd,
    input  logic           clr_b_valid,
    input  logic [RAW-1:0] clr_b_rd,
    input  logic [RAW-1:0] lk_rs1,
    input  logic [RAW-1:0] lk_rs2,
    output logic           busy_rs1,
    output logic           busy_rs2
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears first so a same-edge set on the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_a_valid) busy_d[clr_a_rd] = 1'b0;
        if (clr_b_valid) busy_d[clr_b_rd] = 1'b0;
        if (set_valid && (set_rd != '0)) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_rs1 = busy_q[lk_rs1];
    assign busy_rs2 = busy_q[lk_rs2];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: arbitrates NSRC requesters onto the regfile's two
// write ports (A, B) with a rotating priority pointer, and tracks pending
// destinations in a busy scoreboard.
// Ports: req_valid/req_rd/req_data in, req_ready out (combinational);
// wa_*/wb_* registered write ports; iss_valid/iss_rd marks busy;
// lk_rs1/lk_rs2 lookups -> busy_rs1/busy_rs2 (combinational).
// Optional macro WB_FWD_EN adds fwd_rs*_hit/fwd_rs*_data bypass outputs
// from the registered write ports and masks busy_rs* on a hit.
module regfile_wb_scheduler
    import regfile_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC-1:0]      req_valid,
    input  logic [NSRC*RAW-1:0]  req_rd,
    input  logic [NSRC*XLEN-1:0] req_data,
    output logic [NSRC-1:0]      req_ready,
    output logic                 wa_valid,
    output logic [RAW-1:0]       wa_rd,
    output logic [XLEN-1:0]      wa_data,
    output logic                 wb_valid,
    output logic [RAW-1:0]       wb_rd,
    output logic [XLEN-1:0]      wb_data,
    input  logic                 iss_valid,
    input  logic [RAW-1:0]       iss_rd,
    input  logic [RAW-1:0]       lk_rs1,
    input  logic [RAW-1:0]       lk_rs2,
    output logic                 busy_rs1,
    output logic                 busy_rs2
`ifdef WB_FWD_EN
    ,
    output logic                 fwd_rs1_hit,
    output logic [XLEN-1:0]      fwd_rs1_data,
    output logic                 fwd_rs2_hit,
    output logic [XLEN-1:0]      fwd_rs2_data
`endif
);

    src_idx_t       rr_q, rr_d;
    wb_port_t       wa_q, wa_d;
    wb_port_t       wb_q, wb_d;
    src_idx_t       idx;
    src_idx_t       last_acc;
    logic           acc_any;
    logic [RAW-1:0] rd_k;
    logic           sb_busy_rs1, sb_busy_rs2;

    // Rotating scan from rr: first real write -> A, next non-conflicting -> B.
    // rd==0 requests are accepted without a port; scan ends once B is taken.
    always_comb begin
        req_ready = '0;
        wa_d      = '0;
        wb_d      = '0;
        acc_any   = 1'b0;
        last_acc  = rr_q;
        idx       = '0;
        rd_k      = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            idx  = src_wrap(32'(rr_q) + k);
            rd_k = req_rd[32'(idx)*RAW +: RAW];
            if (req_valid[idx] && !wb_d.valid) begin
                if (rd_k == '0) begin
                    req_ready[idx] = 1'b1;
                    acc_any        = 1'b1;
                    last_acc       = idx;
                end else if (!wa_d.valid) begin
                    req_ready[idx] = 1'b1;
                    acc_any        = 1'b1;
                    last_acc       = idx;
                    wa_d = '{valid: 1'b1, rd: rd_k, data: req_data[32'(idx)*XLEN +: XLEN]};
                end else if (rd_k != wa_d.rd) begin
                    req_ready[idx] = 1'b1;
                    acc_any        = 1'b1;
                    last_acc       = idx;
                    wb_d = '{valid: 1'b1, rd: rd_k, data: req_data[32'(idx)*XLEN +: XLEN]};
                end
            end
        end
        rr_d = acc_any ? src_wrap(32'(last_acc) + 32'd1) : rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
            wa_q <= '0;
            wb_q <= '0;
        end else begin
            rr_q <= rr_d;
            wa_q <= wa_d;
            wb_q <= wb_d;
        end
    end

    assign wa_valid = wa_q.valid;
    assign wa_rd    = wa_q.rd;
    assign wa_data  = wa_q.data;
    assign wb_valid = wb_q.valid;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;

    // Busy bits clear on the edge the regfile consumes the registered write.
    reg_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid   (iss_valid),
        .set_rd      (iss_rd),
        .clr_a_valid (wa_q.valid),
        .clr_a_rd    (wa_q.rd),
        .clr_b_valid (wb_q.valid),
        .clr_b_rd    (wb_q.rd),
        .lk_rs1      (lk_rs1),
        .lk_rs2      (lk_rs2),
        .busy_rs1    (sb_busy_rs1),
        .busy_rs2    (sb_busy_rs2)
    );

`ifdef WB_FWD_EN
    // Bypass from the registered ports; port B is checked last so it wins.
    always_comb begin
        fwd_rs1_hit  = 1'b0;
        fwd_rs1_data = '0;
        fwd_rs2_hit  = 1'b0;
        fwd_rs2_data = '0;
        if (lk_rs1 != '0) begin
            if (wa_q.valid && (wa_q.rd == lk_rs1)) begin
                fwd_rs1_hit  = 1'b1;
                fwd_rs1_data = wa_q.data;
            end
            if (wb_q.valid && (wb_q.rd == lk_rs1)) begin
                fwd_rs1_hit  = 1'b1;
                fwd_rs1_data = wb_q.data;
            end
        end
        if (lk_rs2 != '0) begin
            if (wa_q.valid && (wa_q.rd == lk_rs2)) begin
                fwd_rs2_hit  = 1'b1;
                fwd_rs2_data = wa_q.data;
            end
            if (wb_q.valid && (wb_q.rd == lk_rs2)) begin
                fwd_rs2_hit  = 1'b1;
                fwd_rs2_data = wb_q.data;
            end
        end
    end

    assign busy_rs1 = sb_busy_rs1 & ~fwd_rs1_hit;
    assign busy_rs2 = sb_busy_rs2 & ~fwd_rs2_hit;
`else
    assign busy_rs1 = sb_busy_rs1;
    assign busy_rs2 = sb_busy_rs2;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios followed by
// randomized traffic, checked by a queue-based scoreboard against a reference model.
module tb_regfile_wb_scheduler;
    import regfile_sched_pkg::*;

    typedef struct packed {
        wb_port_t a;
        wb_port_t b;
    } out_rec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NSRC-1:0]      req_valid = '0;
    logic [NSRC*RAW-1:0]  req_rd = '0;
    logic [NSRC*XLEN-1:0] req_data = '0;
    logic [NSRC-1:0]      req_ready;
    logic                 wa_valid, wb_valid;
    logic [RAW-1:0]       wa_rd, wb_rd;
    logic [XLEN-1:0]      wa_data, wb_data;
    logic                 iss_valid = 1'b0;
    logic [RAW-1:0]       iss_rd = '0;
    logic [RAW-1:0]       lk_rs1 = '0;
    logic [RAW-1:0]       lk_rs2 = '0;
    logic                 busy_rs1, busy_rs2;
`ifdef WB_FWD_EN
    logic                 fwd_rs1_hit, fwd_rs2_hit;
    logic [XLEN-1:0]      fwd_rs1_data, fwd_rs2_data;
`endif

    regfile_wb_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wa_valid  (wa_valid),
        .wa_rd     (wa_rd),
        .wa_data   (wa_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .lk_rs1    (lk_rs1),
        .lk_rs2    (lk_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2)
`ifdef WB_FWD_EN
        ,
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_rs2_data (fwd_rs2_data)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Driver-side request image for the next cycle.
    logic [NSRC-1:0] drv_valid = '0;
    logic [RAW-1:0]  drv_rd   [NSRC];
    logic [XLEN-1:0] drv_data [NSRC];
    logic            drv_iss_v = 1'b0;
    logic [RAW-1:0]  drv_iss_rd = '0;
    logic [RAW-1:0]  drv_lk1 = '0;
    logic [RAW-1:0]  drv_lk2 = '0;

    // Reference model state.
    int              m_rr = 0;
    bit              m_busy [NREG];
    logic [XLEN-1:0] m_rf   [NREG];
    logic [XLEN-1:0] dut_rf [NREG];
    out_rec_t        cur_out = '0;
    logic [NSRC-1:0] last_ready = '0;

    out_rec_t exp_q[$];
    bit       mon_en = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every cycle the DUT presents one write-port state; compare it
    // against the oldest predicted state and mirror writes into a shadow regfile.
    initial begin
        out_rec_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL mon_underflow: got empty queue, expected a record at %0t", $time);
                end else begin
                    r = exp_q.pop_front();
                    chk("port_a", {26'd0, wa_valid, wa_rd, wa_data}, {26'd0, r.a});
                    chk("port_b", {26'd0, wb_valid, wb_rd, wb_data}, {26'd0, r.b});
                    if (wa_valid) dut_rf[wa_rd] = wa_data;
                    if (wb_valid) dut_rf[wb_rd] = wb_data;
                end
            end
        end
    end

    task automatic idle_drv();
        drv_valid = '0;
        for (int i = 0; i < NSRC; i++) begin
            drv_rd[i]   = '0;
            drv_data[i] = '0;
        end
        drv_iss_v  = 1'b0;
        drv_iss_rd = '0;
    endtask

    task automatic set_src(input int s, input logic [RAW-1:0] rd, input logic [XLEN-1:0] d);
        drv_valid[s] = 1'b1;
        drv_rd[s]    = rd;
        drv_data[s]  = d;
    endtask

    // One clock: apply the driver image, check combinational outputs against
    // the model, then advance the model and queue the expected write ports.
    task automatic step();
        int              order[$];
        int              pa, pb, scan_end, last_pos, s;
        logic [NSRC-1:0] m_ready;
        out_rec_t        nxt;
        logic            hit1, hit2;
        @(posedge clk);
        #1;
        req_valid = drv_valid;
        for (int i = 0; i < NSRC; i++) begin
            req_rd[i*RAW +: RAW]    = drv_rd[i];
            req_data[i*XLEN +: XLEN] = drv_data[i];
        end
        iss_valid = drv_iss_v;
        iss_rd    = drv_iss_rd;
        lk_rs1    = drv_lk1;
        lk_rs2    = drv_lk2;
        #1;
        for (int k = 0; k < NSRC; k++) order.push_back((m_rr + k) % NSRC);
        pa = -1;
        pb = -1;
        for (int i = 0; i < NSRC; i++)
            if (pa < 0 && drv_valid[order[i]] && drv_rd[order[i]] != 0) pa = i;
        if (pa >= 0)
            for (int i = pa + 1; i < NSRC; i++)
                if (pb < 0 && drv_valid[order[i]] && drv_rd[order[i]] != 0 &&
                    drv_rd[order[i]] != drv_rd[order[pa]]) pb = i;
        scan_end = (pb >= 0) ? pb : NSRC - 1;
        m_ready  = '0;
        last_pos = -1;
        for (int i = 0; i <= scan_end; i++) begin
            s = order[i];
            if (drv_valid[s] && (drv_rd[s] == 0 || i == pa || i == pb)) begin
                m_ready[s] = 1'b1;
                last_pos   = i;
            end
        end
        nxt = '0;
        if (pa >= 0) nxt.a = '{valid: 1'b1, rd: drv_rd[order[pa]], data: drv_data[order[pa]]};
        if (pb >= 0) nxt.b = '{valid: 1'b1, rd: drv_rd[order[pb]], data: drv_data[order[pb]]};

        hit1 = 1'b0;
        hit2 = 1'b0;
`ifdef WB_FWD_EN
        hit1 = (drv_lk1 != 0) && ((cur_out.a.valid && cur_out.a.rd == drv_lk1) ||
                                  (cur_out.b.valid && cur_out.b.rd == drv_lk1));
        hit2 = (drv_lk2 != 0) && ((cur_out.a.valid && cur_out.a.rd == drv_lk2) ||
                                  (cur_out.b.valid && cur_out.b.rd == drv_lk2));
        chk("fwd_rs1_hit", 64'(fwd_rs1_hit), 64'(hit1));
        chk("fwd_rs2_hit", 64'(fwd_rs2_hit), 64'(hit2));
`endif
        chk("req_ready", 64'(req_ready), 64'(m_ready));
        chk("busy_rs1", 64'(busy_rs1), 64'(m_busy[drv_lk1] && drv_lk1 != 0 && !hit1));
        chk("busy_rs2", 64'(busy_rs2), 64'(m_busy[drv_lk2] && drv_lk2 != 0 && !hit2));

        if (cur_out.a.valid) m_busy[cur_out.a.rd] = 1'b0;
        if (cur_out.b.valid) m_busy[cur_out.b.rd] = 1'b0;
        if (drv_iss_v && drv_iss_rd != 0) m_busy[drv_iss_rd] = 1'b1;
        if (last_pos >= 0) m_rr = (order[last_pos] + 1) % NSRC;
        if (nxt.a.valid) m_rf[nxt.a.rd] = nxt.a.data;
        if (nxt.b.valid) m_rf[nxt.b.rd] = nxt.b.data;
        exp_q.push_back(nxt);
        cur_out    = nxt;
        last_ready = m_ready;
    endtask

    // Asynchronous reset mid-cycle, then release with the model realigned.
    task automatic do_reset();
        mon_en    = 1'b0;
        req_valid = '0;
        iss_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_wa_valid", 64'(wa_valid), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_busy_rs1", 64'(busy_rs1), 64'd0);
        m_rr = 0;
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        cur_out = '0;
        exp_q.delete();
        idle_drv();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        mon_en = 1'b1;
    endtask

    logic [RAW-1:0]  pend_rd   [NSRC];
    logic [XLEN-1:0] pend_data [NSRC];
    logic [NSRC-1:0] pend_v;

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = '0;
            dut_rf[r] = '0;
            m_busy[r] = 1'b0;
        end
        idle_drv();
        do_reset();

        // Reset while a grant to rd=5 is on port A and x5 is busy.
        drv_lk1 = 5'd5;
        drv_iss_v = 1'b1; drv_iss_rd = 5'd5;
        step();
        idle_drv(); set_src(0, 5'd5, 32'h5555);
        step();
        idle_drv();
        step();
        chk("t1_pre_wa_valid", 64'(wa_valid), 64'd1);
        chk("t1_pre_busy_rs1", 64'(busy_rs1), 64'd1);
        lk_rs1 = 5'd5;
        do_reset();

        // Two independent writes in one cycle.
        idle_drv(); set_src(0, 5'd3, 32'h11); set_src(1, 5'd4, 32'h22);
        step();
        idle_drv();
        step();
        chk("t2_wa", {26'd0, wa_valid, wa_rd, wa_data}, {26'd0, 1'b1, 5'd3, 32'h11});
        chk("t2_wb", {26'd0, wb_valid, wb_rd, wb_data}, {26'd0, 1'b1, 5'd4, 32'h22});

        // Same-rd conflict: src2 waits a cycle and its value lands last.
        do_reset();
        idle_drv(); set_src(0, 5'd7, 32'hA0); set_src(2, 5'd7, 32'hC2);
        step();
        chk("t3_ready0", 64'(req_ready), 64'(3'b001));
        idle_drv(); set_src(2, 5'd7, 32'hC2);
        step();
        chk("t3_ready1", 64'(req_ready), 64'(3'b100));
        idle_drv();
        step();
        step();
        chk("t3_x7", 64'(dut_rf[7]), 64'(32'hC2));

        // All three held: grant pairs rotate {0,1},{2,0},{1,2}.
        do_reset();
        idle_drv(); set_src(0, 5'd1, 32'h101); set_src(1, 5'd2, 32'h202); set_src(2, 5'd3, 32'h303);
        step();
        chk("t4_ready0", 64'(req_ready), 64'(3'b011));
        step();
        chk("t4_ready1", 64'(req_ready), 64'(3'b101));
        step();
        chk("t4_ready2", 64'(req_ready), 64'(3'b110));

        // Busy stays set from issue until the regfile write edge.
        do_reset();
        idle_drv(); drv_lk1 = 5'd9; drv_iss_v = 1'b1; drv_iss_rd = 5'd9;
        step();
        idle_drv();
        step();
        chk("t5_busy_after_iss", 64'(busy_rs1), 64'd1);
        set_src(1, 5'd9, 32'h99);
        step();
        idle_drv();
        step();
        chk("t5_busy_write_cycle", 64'(busy_rs1), 64'd1);
        step();
        chk("t5_busy_cleared", 64'(busy_rs1), 64'd0);

        // rd==0 is accepted but never written.
        idle_drv(); set_src(1, 5'd0, 32'hFFFF);
        step();
        chk("t6_ready", 64'(req_ready), 64'(3'b010));
        idle_drv();
        step();
        chk("t6_no_write", 64'({wa_valid, wb_valid}), 64'd0);

        // Random traffic with held requests; small rd range provokes conflicts.
        pend_v = '0;
        for (int i = 0; i < NSRC; i++) begin
            pend_rd[i]   = '0;
            pend_data[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!pend_v[i] && $urandom_range(0, 99) < 60) begin
                    pend_v[i]    = 1'b1;
                    pend_rd[i]   = RAW'($urandom_range(0, 7));
                    pend_data[i] = XLEN'($urandom);
                end
                drv_valid[i] = pend_v[i];
                drv_rd[i]    = pend_rd[i];
                drv_data[i]  = pend_data[i];
            end
            drv_iss_v  = ($urandom_range(0, 99) < 30);
            drv_iss_rd = RAW'($urandom_range(0, 7));
            drv_lk1    = RAW'($urandom_range(0, 7));
            drv_lk2    = RAW'($urandom_range(0, 7));
            step();
            pend_v = pend_v & ~last_ready;
        end

        idle_drv();
        repeat (4) step();
        mon_en = 1'b0;
        for (int r = 0; r < NREG; r++) chk("regfile", 64'(dut_rf[r]), 64'(m_rf[r]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
